// File: rtl/serial_adder_sub.sv
// Bit-serial adder/subtractor: one full-adder cell plus carry flop,
// LSB-first, with valid/ready on operands and result.
module serial_adder_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy,
  output logic             bit_out,
  output logic             bit_valid
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_sr;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             s;
  logic             c_nxt;
  logic             last;

  assign s     = a_sr[0] ^ b_sr[0] ^ carry;
  assign c_nxt = (a_sr[0] & b_sr[0])
               | (a_sr[0] & carry)
               | (b_sr[0] & carry);
  assign last  = (cnt == CW'(WIDTH - 1));

  assign in_ready  = (state == IDLE);
  assign busy      = (state == CALC);
  assign bit_valid = (state == CALC);
  assign out_valid = (state == DONE);
  assign bit_out   = (state == CALC) & s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      sum_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum    <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      unique case (1'b1)
        (state == IDLE): begin
          if (in_valid) begin
            a_sr  <= a;
            b_sr  <= sub ? ~b : b;
            carry <= sub ? 1'b1 : cin;
            cnt   <= '0;
            state <= CALC;
          end
        end
        (state == CALC): begin
          sum_sr <= {s, sum_sr[WIDTH-1:1]};
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          carry  <= c_nxt;
          cnt    <= cnt + 1'b1;
          // carry still holds the carry into the MSB here
          if (last) begin
            sum   <= {s, sum_sr[WIDTH-1:1]};
            cout  <= c_nxt;
            ovf   <= carry ^ c_nxt;
            state <= DONE;
          end
        end
        (state == DONE): begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_sub.sv
// Bench for serial_adder_sub: WIDTH 8/2/32 instances checked
// every cycle against an arithmetic reference model.
module tb_serial_adder_sub;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid = 1'b0;
  logic        cin = 1'b0;
  logic        sub = 1'b0;
  logic        out_ready = 1'b0;
  logic [63:0] a = '0;
  logic [63:0] b = '0;
  int          sel = 0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  logic        iv8, iv2, iv32;
  logic        ir8, ir2, ir32;
  logic        ov8, ov2, ov32;
  logic [7:0]  s8;
  logic [1:0]  s2;
  logic [31:0] s32;
  logic        co8, co2, co32;
  logic        of8, of2, of32;
  logic        bz8, bz2, bz32;
  logic        bo8, bo2, bo32;
  logic        bv8, bv2, bv32;

  assign iv8  = in_valid && sel == 0;
  assign iv2  = in_valid && sel == 1;
  assign iv32 = in_valid && sel == 2;

  serial_adder_sub #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8),
    .a(a[7:0]), .b(b[7:0]), .cin(cin), .sub(sub),
    .out_valid(ov8), .out_ready(out_ready), .sum(s8),
    .cout(co8), .ovf(of8), .busy(bz8), .bit_out(bo8),
    .bit_valid(bv8));

  serial_adder_sub #(.WIDTH(2)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2),
    .a(a[1:0]), .b(b[1:0]), .cin(cin), .sub(sub),
    .out_valid(ov2), .out_ready(out_ready), .sum(s2),
    .cout(co2), .ovf(of2), .busy(bz2), .bit_out(bo2),
    .bit_valid(bv2));

  serial_adder_sub #(.WIDTH(32)) u32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32),
    .a(a[31:0]), .b(b[31:0]), .cin(cin), .sub(sub),
    .out_valid(ov32), .out_ready(out_ready), .sum(s32),
    .cout(co32), .ovf(of32), .busy(bz32), .bit_out(bo32),
    .bit_valid(bv32));

  logic        m_ir, m_ov, m_co, m_of, m_bz, m_bo, m_bv;
  logic [63:0] m_sum;
  int          wsel;

  always_comb begin
    m_ir = ir8; m_ov = ov8; m_co = co8; m_of = of8;
    m_bz = bz8; m_bo = bo8; m_bv = bv8;
    m_sum = {56'd0, s8};
    wsel = 8;
    if (sel == 1) begin
      m_ir = ir2; m_ov = ov2; m_co = co2; m_of = of2;
      m_bz = bz2; m_bo = bo2; m_bv = bv2;
      m_sum = {62'd0, s2};
      wsel = 2;
    end else if (sel == 2) begin
      m_ir = ir32; m_ov = ov32; m_co = co32; m_of = of32;
      m_bz = bz32; m_bo = bo32; m_bv = bv32;
      m_sum = {32'd0, s32};
      wsel = 32;
    end
  end

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  function automatic longint sext(input logic [63:0] v, input int w);
    longint x;
    x = longint'(v << (64 - w));
    return x >>> (64 - w);
  endfunction

  // Plain-arithmetic reference: unsigned sum for sum/cout,
  // signed range test for overflow.
  task automatic model(input int w, input logic [63:0] aa,
                       input logic [63:0] bb, input logic c,
                       input logic sb, output logic [63:0] es,
                       output logic ec, output logic eo);
    logic [63:0] mask;
    logic [64:0] full;
    longint sa, sbv, r, hi, lo;
    mask = (64'd1 << w) - 64'd1;
    if (sb) full = {1'b0, aa & mask} - {1'b0, bb & mask};
    else    full = {1'b0, aa & mask} + {1'b0, bb & mask}
                   + {64'd0, c};
    es = full[63:0] & mask;
    if (sb) ec = ((aa & mask) >= (bb & mask));
    else    ec = full[w];
    sa  = sext(aa, w);
    sbv = sext(bb, w);
    r   = sb ? sa - sbv : sa + sbv + longint'(c);
    hi  = (longint'(1) <<< (w - 1)) - 1;
    lo  = -(longint'(1) <<< (w - 1));
    eo  = (r > hi) || (r < lo);
  endtask

  int          phase = 0;
  int          bitn = 0;
  logic [63:0] e_sum;
  logic        e_co, e_of;

  always @(negedge clk) begin
    if (!rst_n) begin
      phase = 0;
    end else if (phase == 0) begin
      chk("idle_in_ready", m_ir, 1);
      chk("idle_out_valid", m_ov, 0);
      chk("idle_busy", m_bz, 0);
      if (in_valid) begin
        model(wsel, a, b, cin, sub, e_sum, e_co, e_of);
        bitn = 0;
        phase = 1;
      end
    end else if (phase == 1) begin
      chk("calc_busy", m_bz, 1);
      chk("calc_bit_valid", m_bv, 1);
      chk("calc_in_ready", m_ir, 0);
      chk("calc_out_valid", m_ov, 0);
      chk("calc_bit_out", m_bo, e_sum[bitn]);
      bitn++;
      if (bitn == wsel) phase = 2;
    end else begin
      chk("done_out_valid", m_ov, 1);
      chk("done_busy", m_bz, 0);
      chk("done_bit_valid", m_bv, 0);
      chk("done_in_ready", m_ir, 0);
      chk("done_sum", m_sum, e_sum);
      chk("done_cout", m_co, e_co);
      chk("done_ovf", m_of, e_of);
      if (out_ready) phase = 0;
    end
  end

  logic [63:0] rs;
  logic        rc, ro;

  task automatic do_op(input int s, input logic [63:0] aa,
                       input logic [63:0] bb, input logic c,
                       input logic sb, input int hold,
                       input bit poke);
    int n;
    @(posedge clk) #1;
    sel = s; a = aa; b = bb; cin = c; sub = sb;
    in_valid = 1'b1;
    @(posedge clk) #1;
    in_valid = 1'b0;
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    cin = ~c; sub = ~sb;
    n = 0;
    while (!m_ov && n < 200) begin
      if (poke) begin
        in_valid = 1'b1;
        a = 64'h11;
      end
      @(negedge clk);
      n++;
    end
    if (!m_ov) chk("result_timeout", {63'd0, m_ov}, 1);
    rs = m_sum; rc = m_co; ro = m_of;
    @(posedge clk) #1;
    in_valid = 1'b0;
    repeat (hold) @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk) #1;
    out_ready = 1'b0;
  endtask

  logic [63:0] ps;
  logic        pc, po;

  initial begin
    #200000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_in_ready", m_ir, 1);
    chk("rst_out_valid", m_ov, 0);
    chk("rst_busy", m_bz, 0);
    chk("rst_bit_valid", m_bv, 0);
    chk("rst_sum", m_sum, 0);
    chk("rst_cout", m_co, 0);
    chk("rst_ovf", m_of, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    model(8, 64'h5A, 64'h3C, 1'b0, 1'b0, ps, pc, po);
    chk("model_add_sum", ps, 64'h96);
    chk("model_add_flags", {62'd0, pc, po}, 64'b01);
    model(8, 64'h80, 64'h01, 1'b0, 1'b1, ps, pc, po);
    chk("model_sub_sum", ps, 64'h7F);
    chk("model_sub_flags", {62'd0, pc, po}, 64'b11);
    model(2, 64'h1, 64'h1, 1'b0, 1'b0, ps, pc, po);
    chk("model_w2_flags", {ps[61:0], pc, po}, 64'b1001);

    do_op(0, 64'h5A, 64'h3C, 1'b0, 1'b0, 0, 1'b0);
    chk("add1_sum", rs, 64'h96);
    chk("add1_flags", {62'd0, rc, ro}, 64'b01);
    do_op(0, 64'hFF, 64'h01, 1'b1, 1'b0, 0, 1'b0);
    chk("add2_sum", rs, 64'h01);
    chk("add2_flags", {62'd0, rc, ro}, 64'b10);
    do_op(0, 64'h10, 64'h20, 1'b0, 1'b1, 5, 1'b1);
    chk("sub1_sum", rs, 64'hF0);
    chk("sub1_flags", {62'd0, rc, ro}, 64'b00);
    do_op(0, 64'h80, 64'h01, 1'b0, 1'b1, 5, 1'b0);
    chk("sub2_sum", rs, 64'h7F);
    chk("sub2_flags", {62'd0, rc, ro}, 64'b11);

    @(posedge clk) #1;
    sel = 0; a = 64'h33; b = 64'h44; cin = 1'b0; sub = 1'b0;
    in_valid = 1'b1;
    @(posedge clk) #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", m_ir, 1);
    chk("mid_rst_busy", m_bz, 0);
    chk("mid_rst_bit_out", m_bo, 0);
    chk("mid_rst_bit_valid", m_bv, 0);
    chk("mid_rst_out_valid", m_ov, 0);
    chk("mid_rst_sum", m_sum, 0);
    chk("mid_rst_cout", m_co, 0);
    chk("mid_rst_ovf", m_of, 0);
    @(negedge clk) #2 rst_n = 1'b1;
    do_op(0, 64'h01, 64'h01, 1'b0, 1'b0, 1, 1'b0);
    chk("post_rst_sum", rs, 64'h02);

    for (int s = 1; s <= 2; s++) begin
      for (int i = 0; i < 200; i++) begin
        do_op(s, {$urandom, $urandom}, {$urandom, $urandom},
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              int'($urandom_range(0, 2)), 1'b0);
      end
    end

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
